// File: rtl/change_word_packer.sv
// Change-word packer: captures 48-bit change words with a 12-bit sequence
// number into a small FIFO and serializes each entry as a four-word 16-bit
// frame (header, high, middle, low) on a valid/ready stream.
// update and clear_overflow pass through one input register. This puts the
// header on out_valid two edges after the update is sampled. It also keeps
// the accept/drop decision and its clear in the same cycle.
module change_word_packer #(
  parameter int         DEPTH   = 4,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] data_in,
  input  logic        update,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_last,
  output logic        overflow,
  output logic [7:0]  drop_count,
  input  logic        clear_overflow
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, HDR, W2, W1, W0} state_t;

  state_t        state;
  logic          upd_q;
  logic          clr_q;
  logic [47:0]   data_q;
  logic [59:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [11:0]   seq;
  logic [47:0]   frame;
  logic [59:0]   head;
  logic          fifo_nempty;
  logic          handshake;
  logic          pop;
  logic          push;
  logic          drop;

  assign head        = mem[rptr];
  assign fifo_nempty = (count != '0);
  assign handshake   = out_valid & out_ready;
  // The serializer takes the head entry when idle, or at the end of a frame.
  assign pop         = fifo_nempty & ((state == IDLE) | ((state == W0) & handshake));
  // A full FIFO still accepts when an entry leaves in the same cycle.
  assign push        = upd_q & ((count != FULL_COUNT) | pop);
  assign drop        = upd_q & ~push;

  // Register the upstream strobe, its data and the overflow clear together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_q  <= 1'b0;
      clr_q  <= 1'b0;
      data_q <= '0;
    end else begin
      upd_q  <= update;
      clr_q  <= clear_overflow;
      data_q <= data_in;
    end
  end

  // Storage array; each entry keeps the sequence number assigned at acceptance.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {seq, data_q};
    end
  end

  // FIFO pointers, occupancy and the sequence counter, which advances only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      seq   <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
        seq  <= seq + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_q) begin
        drop_count <= 8'd1;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 1'b1;
      end
    end else if (clr_q) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  // Serializer FSM with registered stream outputs; words advance only on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_nempty) begin
            frame     <= head[47:0];
            state     <= HDR;
            out_valid <= 1'b1;
            out_first <= 1'b1;
            out_last  <= 1'b0;
            out_data  <= {HDR_TAG, head[59:48]};
          end
        end
        HDR: begin
          if (handshake) begin
            state     <= W2;
            out_first <= 1'b0;
            out_data  <= frame[47:32];
          end
        end
        W2: begin
          if (handshake) begin
            state    <= W1;
            out_data <= frame[31:16];
          end
        end
        W1: begin
          if (handshake) begin
            state    <= W0;
            out_last <= 1'b1;
            out_data <= frame[15:0];
          end
        end
        W0: begin
          if (handshake) begin
            if (fifo_nempty) begin
              frame     <= head[47:0];
              state     <= HDR;
              out_valid <= 1'b1;
              out_first <= 1'b1;
              out_last  <= 1'b0;
              out_data  <= {HDR_TAG, head[59:48]};
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
